// File: rtl/eth_rx.sv
// 10BASE-T Manchester receiver: recovers mid-bit edges, hunts preamble/SFD,
// deserialises LSB-first bytes into the bram write port and reports frame length.
module eth_rx #(
  parameter int unsigned SPB     = 4,
  parameter int unsigned MIN_PRE = 16,
  parameter int unsigned AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          rx_p,
  output logic          bram_wr_en,
  output logic [AW-1:0] bram_wr_addr,
  output logic [7:0]    bram_wr_data,
  output logic          rx_busy,
  output logic          rx_done,
  output logic [AW:0]   rx_len,
  output logic          rx_err
);

  localparam int unsigned Blank = 3 * SPB / 4;
  localparam int unsigned Tout  = 3 * SPB / 2;
  localparam int unsigned TW    = $clog2(Tout + 1);
  localparam int unsigned PW    = $clog2(MIN_PRE + 1);
  localparam int unsigned LW    = AW + 1;

  typedef enum logic [1:0] {StIdle, StPre, StData, StEnd} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          lvl;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] prebits;
  logic          last;
  logic [7:0]    sr;
  logic [2:0]    bitcnt;
  logic [AW:0]   addr;
  logic          ovf;

  logic          trans;
  logic          mid;
  logic          tout;
  logic          bitv;
  logic [7:0]    byte_nxt;

  // In IDLE the first edge is taken as mid-bit; afterwards boundary edges are blanked.
  always_comb begin
    trans    = clk_en && (sync2 != lvl);
    mid      = trans && ((state == StIdle) || (tcnt >= TW'(Blank)));
    tout     = clk_en && !mid && (tcnt >= TW'(Tout));
    bitv     = sync2;
    byte_nxt = {bitv, sr[7:1]};
  end

  assign rx_busy = (state == StPre) || (state == StData);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      lvl          <= 1'b0;
      tcnt         <= '0;
      prebits      <= '0;
      last         <= 1'b0;
      sr           <= '0;
      bitcnt       <= '0;
      addr         <= '0;
      ovf          <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      rx_done      <= 1'b0;
      rx_len       <= '0;
      rx_err       <= 1'b0;
    end else begin
      sync1      <= rx_p;
      sync2      <= sync1;
      bram_wr_en <= 1'b0;
      rx_done    <= 1'b0;

      if (clk_en) begin
        lvl <= sync2;
        if (mid) begin
          tcnt <= '0;
        end else if (tcnt < TW'(Tout)) begin
          tcnt <= tcnt + TW'(1);
        end
      end

      unique case (state)
        StIdle: begin
          if (mid) begin
            state   <= StPre;
            prebits <= PW'(1);
            last    <= bitv;
          end
        end
        StPre: begin
          if (mid) begin
            if (bitv != last) begin
              last <= bitv;
              if (prebits < PW'(MIN_PRE)) prebits <= prebits + PW'(1);
            end else if (bitv && (prebits >= PW'(MIN_PRE))) begin
              state  <= StData;
              addr   <= '0;
              bitcnt <= '0;
              ovf    <= 1'b0;
            end else begin
              state <= StIdle;
            end
          end else if (tout) begin
            state <= StIdle;
          end
        end
        StData: begin
          if (mid) begin
            sr     <= byte_nxt;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              // addr[AW] set means the buffer is full; drop and flag
              if (!addr[AW]) begin
                bram_wr_en   <= 1'b1;
                bram_wr_data <= byte_nxt;
                bram_wr_addr <= addr[AW-1:0];
                addr         <= addr + LW'(1);
              end else begin
                ovf <= 1'b1;
              end
            end
          end else if (tout) begin
            state   <= StEnd;
            rx_done <= 1'b1;
            rx_len  <= addr;
            rx_err  <= ovf || (bitcnt != 3'd0);
          end
        end
        StEnd: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Self-checking bench for eth_rx: Manchester frame generator plus write/done scoreboards.
module tb_eth_rx;
  localparam int SPB     = 4;
  localparam int MIN_PRE = 16;
  localparam int AW      = 10;
  localparam int MAXB    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic          rx_p = 1'b0;
  logic          fast = 1'b0;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [7:0]    bram_wr_data;
  logic          rx_busy;
  logic          rx_done;
  logic [AW:0]   rx_len;
  logic          rx_err;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_done = 0;
  int exp_cnt = 0;
  logic prev_wr = 1'b0;
  logic [17:0] wq[$];
  logic [11:0] dq[$];

  eth_rx #(.SPB(SPB), .MIN_PRE(MIN_PRE), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .rx_p(rx_p),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_len(rx_len), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  // clk_en every other clk normally, every clk in fast mode
  initial forever begin
    @(negedge clk);
    clk_en = fast ? 1'b1 : ~clk_en;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_wr_en) begin
        logic [17:0] e;
        n_wr++;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%02h, expected none",
                   bram_wr_addr, bram_wr_data);
        end else begin
          e = wq.pop_front();
          if ({bram_wr_addr, bram_wr_data} !== e) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                     bram_wr_addr, bram_wr_data, e[17:8], e[7:0]);
          end
        end
        checks++;
        if (prev_wr || rx_done) begin
          errors++;
          $display("FAIL wr_pulse: got prev_wr=%0b rx_done=%0b, expected 0 0", prev_wr, rx_done);
        end
      end
      if (rx_done) begin
        logic [11:0] d;
        n_done++;
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got len=%0d err=%0b, expected none", rx_len, rx_err);
        end else begin
          d = dq.pop_front();
          if ({rx_len, rx_err} !== d) begin
            errors++;
            $display("FAIL done: got len=%0d err=%0b, expected len=%0d err=%0b",
                     rx_len, rx_err, d[11:1], d[0]);
          end
        end
      end
      prev_wr = bram_wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!clk_en);
    end
    #1;
  endtask

  task automatic half(input logic v);
    rx_p = v;
    ticks(SPB / 2);
  endtask

  task automatic send_bit(input logic b);
    half(~b);
    half(b);
  endtask

  task automatic send_raw(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[i]);
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) send_bit((i % 2) == 0);
  endtask

  task automatic start_frame(input int npre);
    exp_cnt = 0;
    send_pre(npre);
    send_raw(8'hD5, 8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [31:0] a;
    a = exp_cnt;
    if (exp_cnt < MAXB) wq.push_back({a[9:0], b});
    exp_cnt++;
    send_raw(b, 8);
  endtask

  task automatic idle_gap();
    rx_p = 1'b1;
    ticks(2 * SPB);
    rx_p = 1'b0;
    ticks(20 * SPB);
  endtask

  task automatic end_frame(input logic partial);
    logic [10:0] len;
    len = (exp_cnt > MAXB) ? 11'(MAXB) : 11'(exp_cnt);
    dq.push_back({len, partial || (exp_cnt > MAXB)});
    idle_gap();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    checks++;
    if ({bram_wr_en, bram_wr_addr, bram_wr_data, rx_busy, rx_done, rx_len, rx_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b addr=%0d data=%02h busy=%0b done=%0b len=%0d err=%0b, expected all 0",
               bram_wr_en, bram_wr_addr, bram_wr_data, rx_busy, rx_done, rx_len, rx_err);
    end
    rst = 1'b0;
    ticks(4);
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    start_frame(56);
    send_byte(8'h01);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_data: got %0b, expected 1", rx_busy);
    end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    end_frame(1'b0);
    checks++;
    if (n_wr - w0 !== 4 || n_done - d0 !== 1 || rx_len !== 11'd4 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL basic: got writes=%0d dones=%0d len=%0d err=%0b, expected 4 1 4 0",
               n_wr - w0, n_done - d0, rx_len, rx_err);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got %0b, expected 0", rx_busy);
    end
  endtask

  task automatic test_counter_payload();
    logic [31:0] ctr;
    logic [7:0] b;
    ctr = 32'h12345678;
    start_frame(56);
    for (int i = 0; i < 60; i++) begin
      b = (i >= 56) ? ctr[8 * (59 - i) +: 8] : 8'(i);
      send_byte(b);
    end
    end_frame(1'b0);
    checks++;
    if (rx_len !== 11'd60 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL counter_len: got len=%0d err=%0b, expected 60 0", rx_len, rx_err);
    end
  endtask

  task automatic test_overflow();
    int w0;
    fast = 1'b1;
    ticks(4);
    w0 = n_wr;
    start_frame(56);
    for (int i = 0; i < 1030; i++) send_byte(8'(i * 7));
    end_frame(1'b0);
    fast = 1'b0;
    ticks(4);
    checks++;
    if (n_wr - w0 !== 1024 || rx_len !== 11'd1024 || rx_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got writes=%0d len=%0d err=%0b, expected 1024 1024 1",
               n_wr - w0, rx_len, rx_err);
    end
  endtask

  task automatic test_truncated();
    int w0;
    w0 = n_wr;
    start_frame(56);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    send_raw(8'h0A, 4);
    end_frame(1'b1);
    checks++;
    if (n_wr - w0 !== 3 || rx_len !== 11'd3 || rx_err !== 1'b1) begin
      errors++;
      $display("FAIL truncated: got writes=%0d len=%0d err=%0b, expected 3 3 1",
               n_wr - w0, rx_len, rx_err);
    end
  endtask

  task automatic test_short_preamble();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    send_pre(8);
    send_raw(8'hD5, 8);
    send_raw(8'h01, 8); send_raw(8'h02, 8); send_raw(8'h03, 8); send_raw(8'h04, 8);
    idle_gap();
    checks++;
    if (n_wr - w0 !== 0 || n_done - d0 !== 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL short_pre: got writes=%0d dones=%0d busy=%0b, expected 0 0 0",
               n_wr - w0, n_done - d0, rx_busy);
    end
    start_frame(56);
    send_byte(8'h5A); send_byte(8'hC3);
    end_frame(1'b0);
    // 10 preamble bits plus 7 alternating SFD bits is just enough
    start_frame(10);
    send_byte(8'hE7);
    end_frame(1'b0);
    checks++;
    if (n_wr - w0 !== 3 || n_done - d0 !== 2 || rx_len !== 11'd1) begin
      errors++;
      $display("FAIL pre_boundary: got writes=%0d dones=%0d len=%0d, expected 3 2 1",
               n_wr - w0, n_done - d0, rx_len);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    start_frame(56);
    send_byte(8'h11); send_byte(8'h22);
    send_raw(8'h33, 4);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_rst: got %0b, expected 1", rx_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bram_wr_en, bram_wr_addr, bram_wr_data, rx_busy, rx_done, rx_len, rx_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got addr=%0d data=%02h busy=%0b len=%0d err=%0b, expected all 0",
               bram_wr_addr, bram_wr_data, rx_busy, rx_len, rx_err);
    end
    rx_p = 1'b0;
    ticks(4);
    rst = 1'b0;
    ticks(20 * SPB);
    checks++;
    if (n_wr - w0 !== 2 || n_done - d0 !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got writes=%0d dones=%0d, expected 2 0", n_wr - w0, n_done - d0);
    end
    start_frame(56);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    end_frame(1'b0);
    checks++;
    if (n_wr - w0 !== 5 || rx_len !== 11'd3) begin
      errors++;
      $display("FAIL after_rst: got writes=%0d len=%0d, expected 5 3", n_wr - w0, rx_len);
    end
  endtask

  task automatic test_nlp();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      rx_p = 1'b1;
      ticks(SPB / 2);
      rx_p = 1'b0;
      ticks(40 * SPB);
    end
    checks++;
    if (n_wr - w0 !== 0 || n_done - d0 !== 0 || rx_busy !== 1'b0 || rx_len !== 11'd3) begin
      errors++;
      $display("FAIL nlp: got writes=%0d dones=%0d busy=%0b len=%0d, expected 0 0 0 3",
               n_wr - w0, n_done - d0, rx_busy, rx_len);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = n_done;
    start_frame(56);
    send_byte(8'hFF); send_byte(8'h00);
    end_frame(1'b0);
    start_frame(56);
    send_byte(8'h80);
    end_frame(1'b0);
    checks++;
    if (n_done - d0 !== 2 || rx_len !== 11'd1 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got dones=%0d len=%0d pending=%0d/%0d, expected 2 1 0/0",
               n_done - d0, rx_len, wq.size(), dq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_counter_payload();
    test_truncated();
    test_short_preamble();
    test_reset_mid();
    test_nlp();
    test_back_to_back();
    test_overflow();
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL pending: got writes=%0d dones=%0d outstanding, expected 0 0",
               wq.size(), dq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx.md
Name: eth_rx

Overview:
- 10BASE-T Manchester receiver; the receive-side counterpart of the transmit path (sender + eth_tx2).
- Recovers bit timing from the rx_p line, hunts the preamble and SFD, and deserialises payload bytes LSB-first.
- Writes the bytes into the shared 1024x8 bram through its write port and reports the frame length on completion.
- Firmware-side logic reads the frame from the bram read port after rx_done.

Parameters:
SPB, 4, clk_en ticks per Manchester bit (even, >= 4)
MIN_PRE, 16, alternating preamble bits required before SFD is accepted
AW, 10, bram address width; max frame = 2**AW bytes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clk_en  in  1  sample strobe; all timing is counted in clk_en ticks
rx_p  in  1  raw receive line (asynchronous)
bram_wr_en  out  1  one-clk write strobe
bram_wr_addr  out  AW  byte address, 0 = first byte after SFD
bram_wr_data  out  8  received byte
rx_busy  out  1  high while in PRE or DATA
rx_done  out  1  one-clk pulse at end of frame
rx_len  out  AW+1  bytes written in last frame, held until next rx_done
rx_err  out  1  status of last frame, valid with rx_done, held with rx_len

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0; counters and shift register cleared.
- Input sync: rx_p passes through 2 flops on every clk. The decoder uses the synced value only on clk_en ticks. A "transition" means synced level != level at the previous clk_en tick.
- Bit timer tcnt increments each clk_en and is zeroed on every accepted transition.
- Blanking: transitions with tcnt < 3*SPB/4 are boundary edges and are ignored.
- Accepted (mid-bit) transitions are those with tcnt >= 3*SPB/4.
- Bit value = new level (rising = 1, falling = 0).
- Timeout: tcnt reaching 3*SPB/2 with no accepted transition.
- IDLE:
  - first transition is accepted as mid-bit; go to PRE with prebits = 1 and last = bit value.
- PRE:
  - each accepted bit that differs from last increments prebits (saturating).
  - two equal consecutive 0s -> IDLE.
  - two consecutive 1s with prebits >= MIN_PRE -> SFD found; go to DATA with addr = 0, bitcnt = 0.
  - two consecutive 1s with prebits < MIN_PRE -> IDLE.
  - timeout -> IDLE, no rx_done.
- DATA:
  - each bit shifts into sr[7] (LSB-first) and increments bitcnt (3 bits).
  - on the 8th bit, at the next clk: bram_wr_en = 1, bram_wr_data = byte, bram_wr_addr = addr; then addr increments.
  - once addr == 2**AW, further bytes are dropped (no write) and an overflow flag is set.
  - timeout -> END.
- END (one clk):
  - rx_done = 1.
  - rx_len = number of bytes written (max 2**AW).
  - rx_err = overflow OR bitcnt != 0 (partial byte).
  - return to IDLE.
- Trailing TP_IDL high after the last bit falls inside blanking or timeout, so no extra bit is decoded.
- bram_wr_en is never high for more than one clk per byte.
- bram_wr_addr holds its last value between writes.
- Write and rx_done never coincide: the final write precedes END by at least one clk.
- NLP or noise pulses in IDLE enter PRE and fall back to IDLE via timeout or the preamble rules; no write and no rx_done result.
- rx_busy = 1 in PRE and DATA, 0 in IDLE and END.

Test Plan:
- 56 alternating preamble bits + SFD 0xD5 + bytes 01 02 03 04 + 2-bit high idle, SPB=4 -> four writes at addr 0..3 with data 01..04; rx_done once; rx_len=4; rx_err=0.
- Frame carrying the counter payload 0x12345678 written big-endian at 0x38..0x3B within a 60-byte frame -> bram bytes 0x38..0x3B = 12 34 56 78; rx_len=60.
- Frame of 1030 bytes with AW=10 -> exactly 1024 writes (addr 0..1023); rx_len=1024; rx_err=1.
- Frame truncated 4 bits after the last full byte (3 bytes) -> rx_len=3, rx_err=1; no 4th write.
- Only 8 preamble bits before SFD (MIN_PRE=16) -> no writes, no rx_done, back to IDLE; a following valid frame is received correctly.
- Assert rst mid-payload (after 2 bytes) -> outputs 0 immediately, no rx_done; the next full frame writes from addr 0.
- 100 ns NLP pulses every 16 ms on an idle line -> no writes, no rx_done.
